// File: rtl/lab2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_pkg
//  Description : Shared types and defaults for the lab2 datapath scheduler:
//                FSM state encoding, requester-id type, parameter defaults.
//  Revision    : 1.0  initial release
// ============================================================================
package lab2_pkg;

    // Scheduler sequence: IDLE -> ISSUE -> WAIT -> DONE -> IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Requester id: 0 or 1
    typedef logic owner_t;

    localparam int C_WIDTH_DEFAULT   = 32;
    localparam int C_TIMEOUT_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/lab2_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_sched_if
//  Description : Bundle of requester-side and unit-side signals of the lab2
//                scheduler.
//                slave  : scheduler view (takes requests, drives the unit)
//                master : environment view (requesters plus datapath unit)
//  Ports       : req0/x0/ack0/done0, req1/x1/ack1/done1, y, err, busy,
//                mc_start/mc_x (to unit), mc_rdy/mc_y (from unit)
//  Revision    : 1.0  initial release
// ============================================================================
interface lab2_sched_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic [WIDTH-1:0] x0;
    logic             ack0;
    logic             done0;
    logic             req1;
    logic [WIDTH-1:0] x1;
    logic             ack1;
    logic             done1;
    logic [WIDTH-1:0] y;
    logic             err;
    logic             busy;
    logic             mc_start;
    logic [WIDTH-1:0] mc_x;
    logic             mc_rdy;
    logic [WIDTH-1:0] mc_y;

    modport slave (
        input  req0, x0, req1, x1, mc_rdy, mc_y,
        output ack0, done0, ack1, done1, y, err, busy, mc_start, mc_x
    );

    modport master (
        output req0, x0, req1, x1, mc_rdy, mc_y,
        input  ack0, done0, ack1, done1, y, err, busy, mc_start, mc_x
    );
endinterface
`default_nettype wire

// File: rtl/lab2_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_rr_arb
//  Description : Two-way round-robin picker, purely combinational.
//  Ports       : i_req0, i_req1   request levels
//                i_last_grant     owner of the most recently completed op
//                o_gnt            selected requester (valid when o_valid)
//                o_valid          at least one requester is asking
//  Revision    : 1.0  initial release
// ============================================================================
module lab2_rr_arb
    import lab2_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  owner_t i_last_grant,
    output owner_t o_gnt,
    output logic   o_valid
);

    // Sole requester wins outright; on a tie the one that was not served last.
    assign o_gnt   = (i_req0 && i_req1) ? ~i_last_grant : i_req1;
    assign o_valid = i_req0 | i_req1;

endmodule
`default_nettype wire

// File: rtl/lab2_sched.sv
`default_nettype none
// ============================================================================
//  Module      : lab2_sched
//  Description : Shares one multicycle datapath unit between two requesters.
//                Round-robin arbitration, one op in flight, registered result,
//                abort with err after TIMEOUT cycles without mc_rdy.
//  Ports       : clk   rising-edge clock
//                rst   asynchronous reset, active low
//                bus   lab2_sched_if.slave (requesters + unit handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module lab2_sched
    import lab2_pkg::*;
#(
    parameter int WIDTH   = C_WIDTH_DEFAULT,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
)(
    input  logic         clk,
    input  logic         rst,
    lab2_sched_if.slave  bus
);

    localparam int             CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    owner_t           r_owner;
    owner_t           r_last_grant;
    logic [CW-1:0]    r_cnt;
    logic             r_err_flag;
    logic [WIDTH-1:0] r_mc_x;
    logic [WIDTH-1:0] r_y;

    owner_t           w_gnt;
    logic             w_valid;
    logic             w_timeout;

    lab2_rr_arb u_arb (
        .i_req0       (bus.req0),
        .i_req1       (bus.req1),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt),
        .o_valid      (w_valid)
    );

    // Last permitted WAIT cycle; mc_rdy in this same cycle still wins.
    assign w_timeout = (r_cnt == C_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_valid) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bus.mc_rdy || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;       // requester 0 wins the first tie
            r_cnt        <= '0;
            r_err_flag   <= 1'b0;
            r_mc_x       <= '0;
            r_y          <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_gnt;
                        r_mc_x  <= w_gnt ? bus.x1 : bus.x0;
                    end
                end
                S_ISSUE: begin
                    r_cnt      <= '0;
                    r_err_flag <= 1'b0;
                end
                S_WAIT: begin
                    if (bus.mc_rdy) begin
                        r_y <= bus.mc_y;
                    end else if (w_timeout) begin
                        r_err_flag <= 1'b1;     // abort: y keeps its old value
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                end
                default: ;
            endcase
        end
    end

    // Control outputs decode straight from state so reset clears them at once.
    assign bus.mc_start = (r_state == S_ISSUE);
    assign bus.ack0     = (r_state == S_ISSUE) && (r_owner == 1'b0);
    assign bus.ack1     = (r_state == S_ISSUE) && (r_owner == 1'b1);
    assign bus.done0    = (r_state == S_DONE)  && (r_owner == 1'b0);
    assign bus.done1    = (r_state == S_DONE)  && (r_owner == 1'b1);
    assign bus.err      = (r_state == S_DONE)  && r_err_flag;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.mc_x     = r_mc_x;
    assign bus.y        = r_y;

endmodule
`default_nettype wire

// File: tb/tb_lab2_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab2_sched
//  Description : Scoreboard bench for lab2_sched. Unit modelled as y = x + 1
//                with rdy UNIT_DLY cycles after start. Expected acks/dones are
//                queued by the stimulus and popped by a negedge monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lab2_sched;

    localparam int C_TIMEOUT = 8;

    typedef struct { int who; logic [31:0] x; } ack_e_t;
    typedef struct { int who; logic err; logic [31:0] y; int lat; } done_e_t;

    logic clk = 1'b0;
    logic rst;

    lab2_sched_if #(.WIDTH(32)) bus ();

    lab2_sched #(.WIDTH(32), .TIMEOUT(C_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_err    = 0;
    int      n_ack    = 0;
    int      n_done   = 0;
    int      exp_acks = 0;
    int      exp_dones = 0;
    int      cyc      = 0;
    int      ack_cyc  = 0;
    ack_e_t  ack_q[$];
    done_e_t done_q[$];
    ack_e_t  ae;
    done_e_t de;

    // unit model controls (written only by the stimulus process)
    int unit_delay = 3;
    bit rdy_never  = 1'b0;
    int spur_req   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // datapath unit model
    initial begin : unit_model
        int cd;
        int spur_seen;
        logic [31:0] ux;
        cd = 0; spur_seen = 0; ux = '0;
        bus.mc_rdy = 1'b0;
        bus.mc_y   = '0;
        forever begin
            @(posedge clk); #1;
            bus.mc_rdy = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mc_rdy = 1'b1;
                    bus.mc_y   = ux + 32'd1;
                end
            end
            if (spur_req != spur_seen) begin
                spur_seen  = spur_req;
                bus.mc_rdy = 1'b1;
                bus.mc_y   = 32'hDEAD_BEEF;
            end
            if (bus.mc_start && !rdy_never) begin
                cd = unit_delay;
                ux = bus.mc_x;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1) begin
            n_ack++;
            ack_cyc = cyc;
            if (ack_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_ack: ack0=%0b ack1=%0b required none", bus.ack0, bus.ack1);
            end else begin
                ae = ack_q.pop_front();
                chk("ack_owner", 32'(bus.ack1), 32'(ae.who));
                chk("ack_mc_start", 32'(bus.mc_start), 32'd1);
                chk("ack_mc_x", bus.mc_x, ae.x);
            end
        end
        if (bus.done0 || bus.done1) begin
            n_done++;
            if (done_q.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL unexpected_done: done0=%0b done1=%0b y=%0h required none", bus.done0, bus.done1, bus.y);
            end else begin
                de = done_q.pop_front();
                chk("done_owner", 32'(bus.done1), 32'(de.who));
                chk("done_err", 32'(bus.err), 32'(de.err));
                chk("done_y", bus.y, de.y);
                if (de.lat != 0) chk("done_latency", 32'(cyc - ack_cyc), 32'(de.lat));
            end
        end
        if (bus.err) chk("err_with_done", 32'(bus.done0 | bus.done1), 32'd1);
    end

    task automatic wait_acks(input int target);
        for (int k = 0; k < 100 && n_ack < target; k++) begin
            @(posedge clk); #1;
        end
        if (n_ack < target) begin
            n_checks++; n_err++;
            $display("FAIL ack_wait: got %0d acks required %0d", n_ack, target);
        end
    endtask

    task automatic wait_dones(input int target);
        for (int k = 0; k < 200 && n_done < target; k++) begin
            @(posedge clk); #1;
        end
        if (n_done < target) begin
            n_checks++; n_err++;
            $display("FAIL done_wait: got %0d dones required %0d", n_done, target);
        end
    endtask

    // one op from a single requester; returns in the first WAIT cycle
    task automatic do_op(input int who, input logic [31:0] x, input bit want_done,
                         input logic err_e, input logic [31:0] y_e, input int lat);
        ack_q.push_back('{who, x});
        exp_acks++;
        if (want_done) begin
            done_q.push_back('{who, err_e, y_e, lat});
            exp_dones++;
        end
        if (who == 0) begin bus.req0 = 1'b1; bus.x0 = x; end
        else          begin bus.req1 = 1'b1; bus.x1 = x; end
        wait_acks(exp_acks);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b0;
        bus.req0 = 1'b0; bus.x0 = '0;
        bus.req1 = 1'b0; bus.x1 = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy, bus.mc_start}), 32'd0);
        chk("rst_y", bus.y, 32'd0);
        chk("rst_mc_x", bus.mc_x, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // both held: order 0,1,0,1
        ack_q.push_back('{0, 32'd10}); done_q.push_back('{0, 1'b0, 32'd11, 4});
        ack_q.push_back('{1, 32'd20}); done_q.push_back('{1, 1'b0, 32'd21, 4});
        ack_q.push_back('{0, 32'd10}); done_q.push_back('{0, 1'b0, 32'd11, 4});
        ack_q.push_back('{1, 32'd20}); done_q.push_back('{1, 1'b0, 32'd21, 4});
        exp_acks += 4; exp_dones += 4;
        bus.x0 = 32'd10; bus.x1 = 32'd20;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_acks(exp_acks);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_dones(exp_dones);

        // single op, ack one cycle after req sampled, 1-cycle start
        ack_q.push_back('{0, 32'd5}); done_q.push_back('{0, 1'b0, 32'd6, 4});
        exp_acks++; exp_dones++;
        bus.req0 = 1'b1; bus.x0 = 32'd5;
        @(posedge clk); #1;
        chk("t1_ack_next_cycle", 32'(bus.ack0), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        @(posedge clk); #1;
        chk("t1_start_one_cycle", 32'(bus.mc_start), 32'd0);
        wait_dones(exp_dones);

        // timeout: unit never answers, y keeps 6
        rdy_never = 1'b1;
        do_op(1, 32'd7, 1'b1, 1'b1, 32'd6, C_TIMEOUT + 1);
        wait_dones(exp_dones);
        chk("t3_busy_low_after", 32'(bus.busy), 32'd0);
        chk("t3_y_held", bus.y, 32'd6);
        rdy_never = 1'b0;

        // spurious rdy in IDLE
        #1 spur_req++;
        repeat (3) begin @(posedge clk); #1; end
        chk("t5_idle_spur_y", bus.y, 32'd6);
        chk("t5_idle_spur_nodone", 32'(n_done), 32'(exp_dones));

        // spurious rdy during ISSUE, real result follows normally
        ack_q.push_back('{0, 32'd60}); done_q.push_back('{0, 1'b0, 32'd61, 4});
        exp_acks++; exp_dones++;
        bus.req0 = 1'b1; bus.x0 = 32'd60;
        #1 spur_req++;
        wait_acks(exp_acks);
        bus.req0 = 1'b0;
        wait_dones(exp_dones);

        // rdy in the last permitted WAIT cycle wins over timeout
        unit_delay = C_TIMEOUT;
        do_op(0, 32'd40, 1'b1, 1'b0, 32'd41, C_TIMEOUT + 1);
        wait_dones(exp_dones);
        unit_delay = 3;

        // req1 pulsed while busy: never served
        do_op(0, 32'd50, 1'b1, 1'b0, 32'd51, 4);
        bus.req1 = 1'b1; bus.x1 = 32'd9;
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        wait_dones(exp_dones);
        repeat (4) begin @(posedge clk); #1; end
        chk("t6_no_ack1", 32'(n_ack), 32'(exp_acks));

        // reset during WAIT
        do_op(0, 32'd3, 1'b0, 1'b0, 32'd0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_ctrl", 32'({bus.ack0, bus.ack1, bus.done0, bus.done1, bus.err, bus.busy, bus.mc_start}), 32'd0);
        chk("t4_rst_y", bus.y, 32'd0);
        chk("t4_rst_mc_x", bus.mc_x, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("t4_late_rdy_nodone", 32'(n_done), 32'(exp_dones));
        chk("t4_y_after", bus.y, 32'd0);

        // tie right after reset goes to requester 0 again
        ack_q.push_back('{0, 32'd70}); done_q.push_back('{0, 1'b0, 32'd71, 4});
        exp_acks++; exp_dones++;
        bus.x0 = 32'd70; bus.x1 = 32'd80;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_acks(exp_acks);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_dones(exp_dones);

        do_op(1, 32'd100, 1'b1, 1'b0, 32'd101, 4);
        wait_dones(exp_dones);

        repeat (3) begin @(posedge clk); #1; end
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
